shift_deser: RTL and testbench

// Serial-to-parallel receiver for the LSB-first stream emitted by the presettable 31-bit shifter.

---
 rtl/shift_pkg.sv | 16 +
 rtl/shift_deser_if.sv | 31 +++
 rtl/shift_deser.sv | 120 ++++++++++++
 tb/tb_shift_deser.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serial deserializer: default word width,
// bit-counter width and the receiver state encoding.
package shift_pkg;

  localparam int SHIFT_WIDTH = 31;
  localparam int CNT_W       = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_SHIFT = SHIFT;

endpackage

// File: rtl/shift_deser_if.sv
// Serial-side strobes plus parallel word handoff and status between the
// receiver and its producer/consumer.
interface shift_deser_if
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
);

  logic             serial_in;
  logic             bit_en;
  logic             frame_start;
  logic             word_ack;
  logic             clr_err;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;
  logic             frame_err;

  modport master (
    output serial_in, bit_en, frame_start, word_ack, clr_err,
    input  word_out, word_valid, busy, bit_cnt, overrun, frame_err
  );

  modport slave (
    input  serial_in, bit_en, frame_start, word_ack, clr_err,
    output word_out, word_valid, busy, bit_cnt, overrun, frame_err
  );

endinterface

// File: rtl/shift_deser.sv
// LSB-first serial-to-parallel receiver: frames WIDTH bits started by
// frame_start, hands the word off with valid/ack and keeps sticky error flags.
module shift_deser
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic         qzt_clk,
  input  logic         rst,
  shift_deser_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       state_r, state_s;
  logic [WIDTH-1:0] sh_r, sh_s;
  logic [WIDTH-1:0] word_r, word_s;
  logic [WIDTH-1:0] shifted_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             valid_r, valid_s;
  logic             over_r, over_s;
  logic             ferr_r, ferr_s;
  logic             busy_r, busy_s;
  logic             complete_s;
  logic             set_ferr_s;
  logic             set_over_s;

  // Frame FSM: shift register, bit counter, completion and resync detection.
  always_comb begin
    shifted_s  = {bus.serial_in, sh_r[WIDTH-1:1]};
    state_s    = state_r;
    sh_s       = sh_r;
    cnt_s      = cnt_r;
    word_s     = word_r;
    complete_s = 1'b0;
    set_ferr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.bit_en && bus.frame_start) begin
          sh_s    = shifted_s;
          cnt_s   = CNT_ONE;
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.bit_en) begin
          sh_s = shifted_s;
          // Old partial bits are left in sh_r; they are all shifted out
          // before the restarted frame can complete.
          if (bus.frame_start) begin
            cnt_s      = CNT_ONE;
            set_ferr_s = 1'b1;
          end else if (cnt_r == CNT_LAST) begin
            complete_s = 1'b1;
            word_s     = shifted_s;
            cnt_s      = {CNT_W{1'b0}};
            state_s    = ST_IDLE;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Handshake and sticky flags; a flag being raised beats clr_err.
  always_comb begin
    set_over_s = complete_s & valid_r & ~bus.word_ack;
    if (complete_s) begin
      valid_s = 1'b1;
    end else if (bus.word_ack) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
    over_s = set_over_s | (over_r & ~bus.clr_err);
    ferr_s = set_ferr_s | (ferr_r & ~bus.clr_err);
    busy_s = (state_s == ST_SHIFT);
  end

  // State and output registers.
  always_ff @(posedge qzt_clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sh_r    <= {WIDTH{1'b0}};
      word_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      valid_r <= 1'b0;
      over_r  <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sh_r    <= sh_s;
      word_r  <= word_s;
      cnt_r   <= cnt_s;
      valid_r <= valid_s;
      over_r  <= over_s;
      ferr_r  <= ferr_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.word_out   = word_r;
  assign bus.word_valid = valid_r;
  assign bus.busy       = busy_r;
  assign bus.bit_cnt    = cnt_r;
  assign bus.overrun    = over_r;
  assign bus.frame_err  = ferr_r;

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: directed word table, hand-written corner sequences,
// then random traffic against a bit-queue reference model.
module tb_shift_deser;
  import shift_pkg::*;

  localparam int WIDTH = 31;

  logic qzt_clk;
  logic rst;
  int   n_chk;
  int   n_err;

  shift_deser_if #(.WIDTH(WIDTH)) bus ();

  shift_deser #(.WIDTH(WIDTH)) dut (
    .qzt_clk (qzt_clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial qzt_clk = 1'b0;
  always #5 qzt_clk = ~qzt_clk;

  // Reference model: the bits of the frame in progress, in arrival order.
  int               m_bits[$];
  logic [WIDTH-1:0] m_word;
  logic             m_valid;
  logic             m_over;
  logic             m_ferr;

  task automatic model_reset();
    m_bits.delete();
    m_word  = '0;
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_ferr  = 1'b0;
  endtask

  task automatic model_step();
    logic             done;
    logic             fe;
    logic             ov;
    logic [WIDTH-1:0] nw;
    done = 1'b0;
    fe   = 1'b0;
    ov   = 1'b0;
    nw   = '0;
    if (bus.bit_en) begin
      if (bus.frame_start) begin
        if (m_bits.size() > 0) fe = 1'b1;
        m_bits.delete();
        m_bits.push_back(int'(bus.serial_in));
      end else if (m_bits.size() > 0) begin
        m_bits.push_back(int'(bus.serial_in));
        if (m_bits.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++) nw[i] = m_bits[i][0];
          m_bits.delete();
          done = 1'b1;
        end
      end
    end
    if (done) begin
      ov      = m_valid && !bus.word_ack;
      m_word  = nw;
      m_valid = 1'b1;
    end else if (bus.word_ack) begin
      m_valid = 1'b0;
    end
    m_over = ov || (m_over && !bus.clr_err);
    m_ferr = fe || (m_ferr && !bus.clr_err);
  endtask

  // One clock: model sees the inputs held for this edge; returns at negedge.
  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    @(posedge qzt_clk);
    @(negedge qzt_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic fs, input int gap);
    bus.serial_in   = b;
    bus.frame_start = fs;
    bus.bit_en      = 1'b1;
    tick();
    bus.bit_en      = 1'b0;
    bus.frame_start = 1'b0;
    bus.serial_in   = 1'($urandom);
    for (int g = 1; g < gap; g++) tick();
  endtask

  task automatic send_word(input logic [WIDTH-1:0] data, input int gap);
    for (int i = 0; i < WIDTH; i++)
      send_bit(data[i], (i == 0), (i == WIDTH - 1) ? 1 : gap);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom), (i == 0), 1);
  endtask

  task automatic pulse_ack();
    bus.word_ack = 1'b1;
    tick();
    bus.word_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
  endtask

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             pre_ack;
    logic             pre_clr;
    logic [WIDTH-1:0] exp_word;
    logic             exp_valid;
    logic             exp_over;
    logic             exp_ferr;
  } vec_t;

  vec_t tbl [0:5];

  initial begin
    logic [WIDTH-1:0] w;
    n_chk = 0;
    n_err = 0;
    tbl[0] = '{31'h12345678, 1'b0, 1'b0, 31'h12345678, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{31'h7FFFFFFF, 1'b1, 1'b0, 31'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{31'h00000001, 1'b1, 1'b0, 31'h00000001, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{31'h0AAAAAAA, 1'b1, 1'b0, 31'h0AAAAAAA, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{31'h15555555, 1'b0, 1'b0, 31'h15555555, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{31'h00ABCDEF, 1'b1, 1'b1, 31'h00ABCDEF, 1'b1, 1'b0, 1'b0};

    bus.serial_in   = 1'b0;
    bus.bit_en      = 1'b0;
    bus.frame_start = 1'b0;
    bus.word_ack    = 1'b0;
    bus.clr_err     = 1'b0;
    rst             = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_word_out", 32'(bus.word_out), 32'h0);
    check("rst_valid",    32'(bus.word_valid), 32'h0);
    check("rst_busy",     32'(bus.busy), 32'h0);
    check("rst_bit_cnt",  32'(bus.bit_cnt), 32'h0);
    check("rst_overrun",  32'(bus.overrun), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);

    // Strobes without frame_start and acks with nothing pending are ignored.
    send_bit(1'b1, 1'b0, 1);
    send_bit(1'b0, 1'b0, 1);
    pulse_ack();
    check("idle_ignore_cnt",   32'(bus.bit_cnt), 32'h0);
    check("idle_ignore_busy",  32'(bus.busy), 32'h0);
    check("idle_ignore_valid", 32'(bus.word_valid), 32'h0);

    for (int v = 0; v < 6; v++) begin
      if (tbl[v].pre_ack) pulse_ack();
      if (tbl[v].pre_clr) pulse_clr();
      send_word(tbl[v].data, 3);
      check($sformatf("tbl%0d_word", v),  32'(bus.word_out), 32'(tbl[v].exp_word));
      check($sformatf("tbl%0d_valid", v), 32'(bus.word_valid), 32'(tbl[v].exp_valid));
      check($sformatf("tbl%0d_over", v),  32'(bus.overrun), 32'(tbl[v].exp_over));
      check($sformatf("tbl%0d_ferr", v),  32'(bus.frame_err), 32'(tbl[v].exp_ferr));
      check($sformatf("tbl%0d_busy", v),  32'(bus.busy), 32'h0);
      check($sformatf("tbl%0d_cnt", v),   32'(bus.bit_cnt), 32'h0);
    end

    // Resync: 10 bits, then a fresh frame_start restarts the word.
    pulse_ack();
    pulse_clr();
    send_partial(10);
    check("resync_cnt10",  32'(bus.bit_cnt), 32'd10);
    check("resync_busy",   32'(bus.busy), 32'h1);
    check("resync_ferr0",  32'(bus.frame_err), 32'h0);
    send_word(31'h00ABCDEF, 2);
    check("resync_ferr1",  32'(bus.frame_err), 32'h1);
    check("resync_word",   32'(bus.word_out), 32'h00ABCDEF);
    check("resync_over",   32'(bus.overrun), 32'h0);

    // Ack collides with the completion of a second word.
    pulse_ack();
    pulse_clr();
    send_word(31'h01234567, 1);
    w = 31'h25A5A5A5;
    for (int i = 0; i < WIDTH - 1; i++) send_bit(w[i], (i == 0), 1);
    bus.word_ack = 1'b1;
    send_bit(w[WIDTH-1], 1'b0, 1);
    bus.word_ack = 1'b0;
    check("coll_valid", 32'(bus.word_valid), 32'h1);
    check("coll_word",  32'(bus.word_out), 32'h25A5A5A5);
    check("coll_over",  32'(bus.overrun), 32'h0);
    pulse_ack();
    check("coll_acked", 32'(bus.word_valid), 32'h0);

    // Asynchronous reset mid-frame, away from any clock edge.
    send_partial(15);
    check("mid_cnt15", 32'(bus.bit_cnt), 32'd15);
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_cnt",  32'(bus.bit_cnt), 32'h0);
    tick();
    rst = 1'b0;
    send_word(31'h2468ACE1, 1);
    check("post_rst_word",  32'(bus.word_out), 32'h2468ACE1);
    check("post_rst_valid", 32'(bus.word_valid), 32'h1);
    check("post_rst_busy",  32'(bus.busy), 32'h0);

    // Overrun raised on the same edge as clr_err: set wins.
    w = 31'h3C3C3C3C;
    for (int i = 0; i < WIDTH - 1; i++) send_bit(w[i], (i == 0), 1);
    bus.clr_err = 1'b1;
    send_bit(w[WIDTH-1], 1'b0, 1);
    bus.clr_err = 1'b0;
    check("setwins_over", 32'(bus.overrun), 32'h1);
    check("setwins_word", 32'(bus.word_out), 32'h3C3C3C3C);
    pulse_clr();
    check("clr_over", 32'(bus.overrun), 32'h0);

    // Random traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      bus.bit_en      = ($urandom_range(1, 0) == 1);
      bus.serial_in   = 1'($urandom);
      bus.frame_start = (m_bits.size() == 0) ? ($urandom_range(2, 0) == 0)
                                             : ($urandom_range(149, 0) == 0);
      bus.word_ack    = ($urandom_range(24, 0) == 0);
      bus.clr_err     = ($urandom_range(59, 0) == 0);
      tick();
      check("rnd_word",  32'(bus.word_out), 32'(m_word));
      check("rnd_valid", 32'(bus.word_valid), 32'(m_valid));
      check("rnd_busy",  32'(bus.busy), 32'(m_bits.size() != 0));
      check("rnd_cnt",   32'(bus.bit_cnt), 32'(m_bits.size()));
      check("rnd_over",  32'(bus.overrun), 32'(m_over));
      check("rnd_ferr",  32'(bus.frame_err), 32'(m_ferr));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
